irq_ctrl: RTL

//  External interrupt controller upstream of the CP0 block. Collects NIRQ device lines,

---
 rtl/irq_ctrl_pkg.sv | 12 +
 rtl/irq_ctrl_if.sv | 13 +
 rtl/irq_prio_enc.sv | 15 +
 rtl/irq_ctrl.sv | 78 +++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register addresses and FSM state encoding shared by the interrupt controller
package irq_ctrl_pkg;
  localparam logic [1:0] IRQ_REG_PENDING = 2'd0;
  localparam logic [1:0] IRQ_REG_MASK = 2'd1;
  localparam logic [1:0] IRQ_REG_EDGE = 2'd2;
  localparam logic [1:0] IRQ_REG_ID = 2'd3;
  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_t;
endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: MMIO register port plus CP0 request/ack/eret handshake
interface irq_ctrl_if #(parameter int IDW = 3);
  logic reg_we;
  logic [1:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic ir_req;
  logic [IDW-1:0] irq_id;
  logic ir_ack;
  logic eret;
  modport master(output reg_we, reg_addr, reg_wdata, ir_ack, eret, input reg_rdata, ir_req, irq_id);
  modport slave(input reg_we, reg_addr, reg_wdata, ir_ack, eret, output reg_rdata, ir_req, irq_id);
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index priority encoder
module irq_prio_enc #(
  parameter int NIRQ = 8,
  parameter int IDW = 3
) (
  input  logic [NIRQ-1:0] req,
  output logic [IDW-1:0]  id,
  output logic            valid
);
  assign valid = |req;
  always_comb begin
    id = '0;
    for (int i = NIRQ - 1; i >= 0; i--) if (req[i]) id = IDW'(i);
  end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: external interrupt controller feeding CP0 ir_in; define IRQ_SYNC_EN for 2-FF input synchronisers
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NIRQ = 8,
  parameter int IDW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq_src,
  irq_ctrl_if.slave       bus
);
  logic [NIRQ-1:0] s, s_prev, pending, mask, edge_sel, active, set, clr, wd;
  logic [IDW-1:0] id, id_n, enc_id;
  logic enc_valid;
  logic [31:0] rd_n;
  irq_state_t state, state_n;
`ifdef IRQ_SYNC_EN
  logic [NIRQ-1:0] sync1, sync2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  assign s = sync2;
`else
  assign s = irq_src;
`endif
  assign wd = NIRQ'(bus.reg_wdata);
  assign active = pending & mask;
  assign set = (edge_sel & s & ~s_prev) | (~edge_sel & s);
  // an acknowledged edge source is consumed; level sources re-pend from the line itself
  assign clr = ({NIRQ{bus.reg_we && bus.reg_addr == IRQ_REG_PENDING}} & wd)
             | ({NIRQ{state == IRQ_REQ && bus.ir_ack}} & edge_sel & (NIRQ'(1) << id));
  assign bus.ir_req = state == IRQ_REQ;
  assign bus.irq_id = id;
  irq_prio_enc #(.NIRQ(NIRQ), .IDW(IDW)) u_enc (.req(active), .id(enc_id), .valid(enc_valid));
  always_comb begin
    state_n = state;
    id_n = id;
    case (state)
      IRQ_IDLE: begin
        state_n = enc_valid ? IRQ_REQ : IRQ_IDLE;
        id_n = enc_valid ? enc_id : id;
      end
      IRQ_REQ: state_n = bus.ir_ack ? IRQ_SERVICE : (active[id] ? IRQ_REQ : IRQ_IDLE);
      IRQ_SERVICE: state_n = bus.eret ? IRQ_IDLE : IRQ_SERVICE;
      default: state_n = IRQ_IDLE;
    endcase
  end
  always_comb begin
    rd_n = bus.reg_addr == IRQ_REG_PENDING ? 32'(pending)
         : bus.reg_addr == IRQ_REG_MASK ? 32'(mask)
         : bus.reg_addr == IRQ_REG_EDGE ? 32'(edge_sel)
         : {state != IRQ_IDLE, {(31 - IDW){1'b0}}, id};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IRQ_IDLE;
      id <= '0;
      pending <= '0;
      mask <= '0;
      edge_sel <= '0;
      s_prev <= '0;
      bus.reg_rdata <= '0;
    end else begin
      state <= state_n;
      id <= id_n;
      pending <= (pending & ~clr) | set;
      if (bus.reg_we && bus.reg_addr == IRQ_REG_MASK) mask <= wd;
      if (bus.reg_we && bus.reg_addr == IRQ_REG_EDGE) edge_sel <= wd;
      s_prev <= s;
      bus.reg_rdata <= rd_n;
    end
endmodule
